calculate_ssd_block: RTL and testbench
======================================

Name: calculate_ssd_block

Overview:
Computes the sum of squared differences (SSD) between a 6x6 left-image window and a 6x6 right-image window for stereo block matching. Each window is cut from a 12-pixel-wide, double-buffered row strip (front buffer followed by back buffer) at a column offset derived from the current x coordinate and the block index. The block sits between the line-buffer/window fetch logic and the disparity (min-SSD) search. It is sequential: one buffer row per clock, one result per request.

Parameters:
BLOCK_DIM, 6, window height/width in pixels; fixed, since port widths depend on it.
PIX_W, 8, bits per grayscale pixel; fixed.
X_W, 9, coordinate width for x and block index, from $clog2(240)+1.
Y_W, 10, coordinate width for y, from $clog2(320)+1.
SSD_W, 23, result width, from $clog2(255*255*36)+1.

Ports:
clk_in  in  1  system clock; all logic on the rising edge.
rst_in  in  1  synchronous, active-high reset.
valid_in  in  1  one-cycle request strobe; all other inputs are sampled on this cycle.
left_current_x  in  9  left window start column, in pixels.
right_current_x  in  9  right window start column, in pixels.
left_current_y  in  10  left window row; latched only, not used in arithmetic.
right_current_y  in  10  right window row; latched only, not used in arithmetic.
left_block_idx  in  9  index of the 6-pixel column group held in the left front buffer.
right_block_idx  in  9  same as left_block_idx, for the right image.
left_front_buffer  in  6x48  rows 0..5 of left columns 6*idx..6*idx+5.
left_back_buffer  in  6x48  rows 0..5 of the next 6 left columns.
right_front_buffer  in  6x48  same as left_front_buffer, for the right image.
right_back_buffer  in  6x48  same as left_back_buffer, for the right image.
valid_out  out  1  one-cycle pulse; ssd_out is valid on this cycle.
ssd_out  out  23  unsigned SSD result; held until the next result.

Behaviour:
- Pixel packing: pixel k (k=0..5) of a 48-bit row is in bits [47-8k -: 8], so pixel 0 is the MSB byte. Concatenated row strip: columns 0..5 come from the front buffer, columns 6..11 from the back buffer.
- Column offset: off = current_x - 6*block_idx, computed per side with signed arithmetic. Window columns are off..off+5 of the strip. Legal range of off is 0..5.
- FSM states and transitions:
  - IDLE: on valid_in=1, latch all inputs, clear the accumulator, set row=0, go to ACCUM.
  - ACCUM: each cycle, add the row SSD of latched row `row` to the accumulator and increment row. After row 5, go to DONE.
  - DONE: register ssd_out = accumulator, assert valid_out for 1 cycle, return to IDLE.
- Row SSD: sum over 6 pixels of (L-R)^2. Differences are 9-bit signed or 8-bit absolute; each square is 16 bits; the row sum needs 19 bits; the accumulator is 23 bits and cannot overflow (maximum 2,340,900).
- Latency: valid_in sampled at edge 0; rows accumulated at edges 1..6; valid_out and ssd_out registered at edge 7. valid_out drops at edge 8. Throughput is one request per 8 cycles.
- valid_in while not in IDLE (busy) is ignored; the request is not queued and inputs are not re-latched.
- Inputs may change freely after the valid_in cycle.
- Illegal offset (either side off<0 or off>5): the computation still runs; on valid_out, ssd_out is forced to 23'h7FFFFF (no-match marker).
- Reset: state returns to IDLE; valid_out=0, ssd_out=0, accumulator=0, row=0. Reset mid-computation aborts with no valid_out. Reset wins over a simultaneous valid_in.

Test Plan:
- Left rows all 0x64 (100) in front and back, right all 0; all x=0, idx=0 -> valid_out 7 cycles after valid_in, ssd_out=360000.
- Left all 0xC8 (200), right all 0; left_x=0, right_x=2, idx=0 -> ssd_out=1440000.
- Left all 0x64, right all 0; right_x=5 (window straddles front/back) -> ssd_out=360000.
- Identical left/right data at equal offsets -> ssd_out=0. Left all 0xFF, right all 0 -> ssd_out=2340900, with no overflow.
- Ordering check: right front pixel0=10, all other right pixels 0; left all 0; right_x=0 -> ssd_out=600. Same data with right_x=1 -> ssd_out=0. Right back pixel0=10, others 0, right_x=1 -> ssd_out=600.
- right_x=7 with idx=0 -> ssd_out=0x7FFFFF. Second valid_in during ACCUM is ignored (exactly one valid_out). rst_in asserted at cycle 3 of ACCUM -> no valid_out, ssd_out=0.

Source files
------------

// File: rtl/calculate_ssd_block.sv
// Sum of squared differences between a 6x6 left and right window cut from double-buffered row strips.
// Result 7 cycles after the request; requests arriving while busy are dropped, not queued.
module calculate_ssd_block #(
  parameter int BLOCK_DIM = 6,
  parameter int PIX_W     = 8,
  parameter int X_W       = 9,
  parameter int Y_W       = 10,
  parameter int SSD_W     = 23
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic                                      valid_in,
  input  logic [X_W-1:0]                            left_current_x,
  input  logic [X_W-1:0]                            right_current_x,
  input  logic [Y_W-1:0]                            left_current_y,
  input  logic [Y_W-1:0]                            right_current_y,
  input  logic [X_W-1:0]                            left_block_idx,
  input  logic [X_W-1:0]                            right_block_idx,
  input  logic [BLOCK_DIM-1:0][BLOCK_DIM*PIX_W-1:0] left_front_buffer,
  input  logic [BLOCK_DIM-1:0][BLOCK_DIM*PIX_W-1:0] left_back_buffer,
  input  logic [BLOCK_DIM-1:0][BLOCK_DIM*PIX_W-1:0] right_front_buffer,
  input  logic [BLOCK_DIM-1:0][BLOCK_DIM*PIX_W-1:0] right_back_buffer,
  output logic                                      valid_out,
  output logic [SSD_W-1:0]                          ssd_out
);

  localparam int ROW_W     = BLOCK_DIM * PIX_W;
  localparam int ROW_IDX_W = $clog2(BLOCK_DIM);
  localparam int OFF_W     = X_W + 4;
  localparam int ROW_SSD_W = 2 * PIX_W + 3;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                                state, state_next;
  logic [ROW_IDX_W-1:0]                  row;
  logic [SSD_W-1:0]                      acc;
  logic [X_W-1:0]                        left_x_lat, right_x_lat, left_idx_lat, right_idx_lat;
  logic [Y_W-1:0]                        left_y_lat, right_y_lat;
  logic [BLOCK_DIM-1:0][ROW_W-1:0]       left_front_lat, left_back_lat;
  logic [BLOCK_DIM-1:0][ROW_W-1:0]       right_front_lat, right_back_lat;
  logic [OFF_W-1:0]                      left_off, right_off;
  logic                                  left_legal, right_legal;
  logic [ROW_IDX_W-1:0]                  left_sel, right_sel;
  logic [ROW_W-1:0]                      left_win, right_win;
  logic [ROW_SSD_W-1:0]                  row_ssd;
  logic                                  unused_y;

  assign unused_y = ^{left_y_lat, right_y_lat};

  // Two's-complement offset: a negative result wraps to a large value, so one unsigned compare covers both bounds.
  assign left_off    = {4'b0, left_x_lat}  - {4'b0, left_idx_lat}  * OFF_W'(BLOCK_DIM);
  assign right_off   = {4'b0, right_x_lat} - {4'b0, right_idx_lat} * OFF_W'(BLOCK_DIM);
  assign left_legal  = left_off  < OFF_W'(BLOCK_DIM);
  assign right_legal = right_off < OFF_W'(BLOCK_DIM);
  assign left_sel    = left_legal  ? left_off[ROW_IDX_W-1:0]  : '0;
  assign right_sel   = right_legal ? right_off[ROW_IDX_W-1:0] : '0;

  assign left_win  = ROW_W'({left_front_lat[row],  left_back_lat[row]}  >> (PIX_W * (BLOCK_DIM - int'(left_sel))));
  assign right_win = ROW_W'({right_front_lat[row], right_back_lat[row]} >> (PIX_W * (BLOCK_DIM - int'(right_sel))));

  function automatic logic [2*PIX_W-1:0] sq_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    logic [PIX_W-1:0] d;
    d = (a > b) ? a - b : b - a;
    return {{PIX_W{1'b0}}, d} * {{PIX_W{1'b0}}, d};
  endfunction

  always_comb begin
    row_ssd = '0;
    for (int j = 0; j < BLOCK_DIM; j++) begin
      row_ssd = row_ssd + ROW_SSD_W'(sq_diff(left_win[ROW_W-1-PIX_W*j -: PIX_W],
                                             right_win[ROW_W-1-PIX_W*j -: PIX_W]));
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_in) state_next = ACCUM;
      ACCUM:   if (row == ROW_IDX_W'(BLOCK_DIM - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      row       <= '0;
      acc       <= '0;
      valid_out <= 1'b0;
      ssd_out   <= '0;
    end else begin
      state     <= state_next;
      valid_out <= 1'b0;
      case (state)
        IDLE: if (valid_in) begin
          acc <= '0;
          row <= '0;
        end
        ACCUM: begin
          acc <= acc + SSD_W'(row_ssd);
          row <= row + 1'b1;
        end
        DONE: begin
          valid_out <= 1'b1;
          ssd_out   <= (left_legal && right_legal) ? acc : {SSD_W{1'b1}};
        end
        default: ;
      endcase
    end
  end

  // Request operands are held for the whole computation so upstream may move on immediately.
  always_ff @(posedge clk_in) begin
    if (!rst_in && state == IDLE && valid_in) begin
      left_x_lat      <= left_current_x;
      right_x_lat     <= right_current_x;
      left_y_lat      <= left_current_y;
      right_y_lat     <= right_current_y;
      left_idx_lat    <= left_block_idx;
      right_idx_lat   <= right_block_idx;
      left_front_lat  <= left_front_buffer;
      left_back_lat   <= left_back_buffer;
      right_front_lat <= right_front_buffer;
      right_back_lat  <= right_back_buffer;
    end
  end

endmodule

// File: tb/tb_calculate_ssd_block.sv
// Self-checking bench for calculate_ssd_block: directed table, busy/reset sequences, random vs. model.
module tb_calculate_ssd_block;

  typedef logic [5:0][47:0] buf_t;
  typedef struct {
    buf_t lf, lb, rf, rb;
    logic [8:0] lx, rx, li, ri;
    int exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [8:0]  lx = '0, rx = '0, li = '0, ri = '0;
  logic [9:0]  ly = '0, ry = '0;
  buf_t        lf = '0, lb = '0, rf = '0, rb = '0;
  logic        valid_out;
  logic [22:0] ssd_out;

  int n_checks = 0;
  int n_fail   = 0;

  calculate_ssd_block dut (
    .clk_in(clk), .rst_in(rst), .valid_in(valid_in),
    .left_current_x(lx), .right_current_x(rx),
    .left_current_y(ly), .right_current_y(ry),
    .left_block_idx(li), .right_block_idx(ri),
    .left_front_buffer(lf), .left_back_buffer(lb),
    .right_front_buffer(rf), .right_back_buffer(rb),
    .valid_out(valid_out), .ssd_out(ssd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic buf_t fill(input logic [7:0] v);
    return {36{v}};
  endfunction

  function automatic buf_t rnd_buf();
    buf_t b;
    for (int r = 0; r < 6; r++) b[r] = {$urandom, 16'($urandom)};
    return b;
  endfunction

  function automatic vec_t mk(input buf_t lf_v, input buf_t lb_v, input buf_t rf_v, input buf_t rb_v,
                              input int lx_v, input int rx_v, input int li_v, input int ri_v, input int e);
    vec_t v;
    v.lf = lf_v; v.lb = lb_v; v.rf = rf_v; v.rb = rb_v;
    v.lx = 9'(lx_v); v.rx = 9'(rx_v); v.li = 9'(li_v); v.ri = 9'(ri_v);
    v.exp = e;
    return v;
  endfunction

  // Pixel c of row r of the 12-wide strip: front holds columns 0..5, back 6..11, pixel 0 is the MSB byte.
  function automatic int pix(input buf_t f, input buf_t b, input int r, input int c);
    buf_t s;
    int k;
    s = (c < 6) ? f : b;
    k = c % 6;
    return int'(s[r][47-8*k -: 8]);
  endfunction

  function automatic int model(input vec_t v);
    int lo, ro, s, d;
    lo = int'(v.lx) - 6 * int'(v.li);
    ro = int'(v.rx) - 6 * int'(v.ri);
    if (lo < 0 || lo > 5 || ro < 0 || ro > 5) return 'h7FFFFF;
    s = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        d = pix(v.lf, v.lb, r, lo + c) - pix(v.rf, v.rb, r, ro + c);
        s += d * d;
      end
    return s;
  endfunction

  task automatic drive(input vec_t v);
    lf = v.lf; lb = v.lb; rf = v.rf; rb = v.rb;
    lx = v.lx; rx = v.rx; li = v.li; ri = v.ri;
    ly = 10'($urandom); ry = 10'($urandom);
  endtask

  task automatic scramble();
    lf = rnd_buf(); lb = rnd_buf(); rf = rnd_buf(); rb = rnd_buf();
    lx = 9'($urandom); rx = 9'($urandom); li = 9'($urandom); ri = 9'($urandom);
  endtask

  task automatic run(input vec_t v, input string name);
    int cyc;
    bit seen;
    @(negedge clk); drive(v); valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0; scramble();
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++; seen = valid_out;
    end
    check({name, " latency"}, cyc, 7);
    check({name, " ssd"}, 32'(ssd_out), v.exp);
    @(negedge clk);
    check({name, " drop"}, 32'(valid_out), 0);
  endtask

  initial begin
    vec_t vt[10];
    vec_t va, vb, vr;
    buf_t z, same_f, same_b, p0;
    int pulses, got, off_l, off_r;

    z = '0;
    same_f = rnd_buf(); same_b = rnd_buf();
    p0 = '0;
    for (int r = 0; r < 6; r++) p0[r][47:40] = 8'd10;

    vt[0] = mk(fill(8'd100), fill(8'd100), z, z, 0, 0, 0, 0, 360000);
    vt[1] = mk(fill(8'd200), fill(8'd200), z, z, 0, 2, 0, 0, 1440000);
    vt[2] = mk(fill(8'd100), fill(8'd100), z, z, 0, 5, 0, 0, 360000);
    vt[3] = mk(same_f, same_b, same_f, same_b, 3, 3, 0, 0, 0);
    vt[4] = mk(fill(8'hFF), fill(8'hFF), z, z, 0, 0, 0, 0, 2340900);
    vt[5] = mk(z, z, p0, z, 0, 0, 0, 0, 600);
    vt[6] = mk(z, z, p0, z, 0, 1, 0, 0, 0);
    vt[7] = mk(z, z, z, p0, 0, 1, 0, 0, 600);
    vt[8] = mk(z, z, z, z, 0, 7, 0, 0, 'h7FFFFF);
    vt[9] = mk(fill(8'd1), z, z, z, 3, 8, 1, 1, 'h7FFFFF);

    repeat (3) @(negedge clk);
    check("reset valid_out", 32'(valid_out), 0);
    check("reset ssd_out", 32'(ssd_out), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run(vt[i], $sformatf("vec%0d", i));

    // Second request while busy must be dropped.
    va = vt[0];
    vb = vt[4];
    @(negedge clk); drive(va); valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    repeat (2) @(negedge clk);
    drive(vb); valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    pulses = 0; got = -1;
    for (int c = 4; c <= 22; c++) begin
      @(negedge clk);
      if (valid_out) begin pulses++; got = int'(ssd_out); end
    end
    check("busy pulses", pulses, 1);
    check("busy ssd", got, 360000);

    // Reset at the third accumulate cycle aborts the request.
    @(negedge clk); drive(vt[1]); valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    check("abort pulses", pulses, 0);
    check("abort ssd", 32'(ssd_out), 0);

    // Reset beats a simultaneous request.
    @(negedge clk); drive(vt[4]); valid_in = 1'b1; rst = 1'b1;
    @(negedge clk); valid_in = 1'b0; rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    check("rst vs valid pulses", pulses, 0);

    for (int i = 0; i < 40; i++) begin
      vr.lf = rnd_buf(); vr.lb = rnd_buf(); vr.rf = rnd_buf(); vr.rb = rnd_buf();
      vr.li = 9'($urandom_range(1, 39));
      vr.ri = 9'($urandom_range(1, 39));
      off_l = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) - 2 + (($urandom_range(0, 1) == 1) ? 8 : 0)
                                          : int'($urandom_range(0, 5));
      off_r = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) - 2 + (($urandom_range(0, 1) == 1) ? 8 : 0)
                                          : int'($urandom_range(0, 5));
      vr.lx = 9'(6 * int'(vr.li) + off_l);
      vr.rx = 9'(6 * int'(vr.ri) + off_r);
      vr.exp = model(vr);
      run(vr, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
